bus_mem: RTL and testbench

//  Word-addressed RAM slave on the shared tri-state data bus. Complements the bus-driving registers and counters.
//  - Address and write data are taken from bus input x.
//  - Read data goes back out on bus output y, enabled by oey.
//  - A programmable wait-state FSM models slow memory; done is signalled with a one-cycle rdy pulse.

---
 rtl/bus_pkg.sv | 14 +
 rtl/bus_mem_if.sv | 27 ++
 rtl/mem_array.sv | 30 +++
 rtl/bus_mem.sv | 106 ++++++++++
 tb/tb_bus_mem.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared constants and types for the bus_mem RAM slave.
package bus_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int WAIT_W         = 4;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT,
    MEM_DONE
  } mem_state_t;

endpackage

// File: rtl/bus_mem_if.sv
// Bus-side signal bundle of the RAM slave: strobes, tri-state data, status.
interface bus_mem_if
  import bus_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                  lda;
  logic                  rd;
  logic                  wr;
  logic                  oey;
  logic [DATA_WIDTH-1:0] x;
  logic [DATA_WIDTH-1:0] y;
  logic                  busy;
  logic                  rdy;

  modport master (
    output lda, rd, wr, oey, x,
    input  y, busy, rdy
  );

  modport slave (
    input  lda, rd, wr, oey, x,
    output y, busy, rdy
  );

endinterface

// File: rtl/mem_array.sv
// Storage for bus_mem: one synchronous write port, one synchronous read port.
// Contents are never reset.
module mem_array
  import bus_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port; rdata holds until the next read.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bus_mem.sv
// Word-addressed RAM slave on the tri-state bus with a programmable
// wait-state FSM. Optional feature macro: BUS_MEM_AUTOINC_EN (address
// post-increments after every completed access).
module bus_mem
  import bus_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int WAIT_STATES = 1
) (
  input  logic     clk,
  input  logic     rst,
  bus_mem_if.slave bus
);

  mem_state_t            state, state_nx;
  logic [WAIT_W-1:0]     cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] dreg;
  logic                  is_rd;
  logic                  dreg_clr;
  logic                  go;
  logic                  access;
  logic                  mem_we;
  logic                  mem_re;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= MEM_IDLE;
    else      state <= state_nx;
  end

  // Next-state decode, request acceptance and access strobe.
  always_comb begin
    state_nx = state;
    go       = 1'b0;
    access   = 1'b0;
    case (state)
      MEM_IDLE: begin
        if (bus.wr || bus.rd) begin
          go       = 1'b1;
          state_nx = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (cnt == '0) begin
          access   = 1'b1;
          state_nx = MEM_DONE;
        end
      end
      MEM_DONE: state_nx = MEM_IDLE;
      default:  state_nx = MEM_IDLE;
    endcase
  end

  // Memory strokes are gated by rst so a reset on the access edge aborts it.
  assign mem_we = access && !is_rd && rst;
  assign mem_re = access &&  is_rd && rst;

  // Address, write data, wait counter and access-type registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= '0;
      addr     <= '0;
      wdata    <= '0;
      is_rd    <= 1'b0;
      dreg_clr <= 1'b1;
    end else begin
      if (go) begin
        cnt   <= WAIT_W'(WAIT_STATES);
        is_rd <= !bus.wr;
        if (bus.wr) wdata <= bus.x;
      end else if (state == MEM_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (state == MEM_IDLE && bus.lda) addr <= bus.x[ADDR_WIDTH-1:0];
`ifdef BUS_MEM_AUTOINC_EN
      if (state == MEM_DONE) addr <= addr + 1'b1;
`endif
      if (mem_re) dreg_clr <= 1'b0;
    end
  end

  mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(addr),
    .wdata(wdata),
    .re   (mem_re),
    .raddr(addr),
    .rdata(rdata)
  );

  // The array's read register is not reset, so reset state is presented as zero
  // until the first completed read.
  assign dreg     = dreg_clr ? '0 : rdata;
  assign bus.y    = bus.oey ? dreg : 'z;
  assign bus.busy = (state != MEM_IDLE);
  assign bus.rdy  = (state == MEM_DONE);

endmodule

// File: tb/tb_bus_mem.sv
// Self-checking bench for bus_mem: transaction-level model plus directed tests.
module tb_bus_mem;
  localparam int WS = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       lda = 1'b0, rd = 1'b0, wr = 1'b0, oey = 1'b0;
  logic [7:0] x = 8'h00;

  bus_mem_if #(.DATA_WIDTH(8)) bif ();
  assign bif.lda = lda;
  assign bif.rd  = rd;
  assign bif.wr  = wr;
  assign bif.oey = oey;
  assign bif.x   = x;

  bus_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_STATES(WS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int         cyc = 0;
  bit         active = 0;
  int         done_cyc = 0;
  bit         m_is_rd = 0;
  logic [7:0] m_addr = 0, acc_addr = 0, m_wdata = 0, m_dreg = 0;
  bit         m_dreg_known = 1;
  logic [7:0] mem_m [256];
  bit         mem_known [256];
  bit         exp_busy = 0, exp_rdy = 0;

  always @(posedge clk) begin
    if (!rst) begin
      active = 0; m_addr = 0; m_dreg = 0; m_dreg_known = 1;
      cyc++;
    end else begin
      if (active && cyc == done_cyc) begin
        active = 0;
`ifdef BUS_MEM_AUTOINC_EN
        m_addr = m_addr + 8'd1;
`endif
      end else if (!active) begin
        if (wr || rd) begin
          active   = 1;
          done_cyc = cyc + 2 + WS;
          m_is_rd  = !wr;
          acc_addr = m_addr;
          if (wr) m_wdata = x;
        end
        if (lda) m_addr = x;
      end
      cyc++;
      if (active && cyc == done_cyc) begin
        if (m_is_rd) begin
          m_dreg = mem_m[acc_addr];
          m_dreg_known = mem_known[acc_addr];
        end else begin
          mem_m[acc_addr] = m_wdata;
          mem_known[acc_addr] = 1;
        end
      end
    end
    exp_busy = active;
    exp_rdy  = active && (cyc == done_cyc);
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 0;
  int rdy_cnt = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", bif.busy, exp_busy);
      chk("rdy", bif.rdy, exp_rdy);
      if (oey && m_dreg_known) chk("y", bif.y, m_dreg);
      if (bif.rdy) rdy_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc_in(input bit l, input bit r, input bit w, input logic [7:0] xv);
    lda = l; rd = r; wr = w; x = xv;
    @(posedge clk); #1;
    lda = 0; rd = 0; wr = 0;
  endtask

  task automatic wait_rdy(output int at);
    at = -1;
    for (int i = 0; i < 30; i++) begin
      if (bif.rdy === 1'b1) begin
        at = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (at < 0) chk("rdy_timeout", 0, 1);
  endtask

  // Issues an access from IDLE, returns request-to-rdy latency, ends back in IDLE.
  task automatic access(input bit r, input bit w, input logic [7:0] xv, output int lat);
    int n, d;
    n = cyc;
    cyc_in(0, r, w, xv);
    wait_rdy(d);
    lat = d - n;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  int lat;

  initial begin
    // Reset
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    cmp_en = 1;
    chk("rst_busy", bif.busy, 1'b0);
    chk("rst_rdy", bif.rdy, 1'b0);
    oey = 1'b1; #1;
    chk("rst_y_oe", bif.y, 8'h00);
    oey = 1'b0;
    idle(1);

    // Write then read, latency WS+2
    cyc_in(1, 0, 0, 8'h10);
    access(0, 1, 8'hA5, lat);
    chk("wr_latency", lat, 3);
    access(1, 0, 8'h00, lat);
    chk("rd_latency", lat, 3);
    oey = 1'b1; #1;
    chk("rd_y_A5", bif.y, 8'hA5);
    oey = 1'b0; #1;
    chk("y_released", (bif.y !== 8'hA5), 1'b1);

    // rd and wr together: write wins, rd dropped
    cyc_in(1, 0, 0, 8'h20);
    rdy_cnt = 0;
    access(1, 1, 8'h3C, lat);
    idle(4);
    chk("rdwr_single_rdy", rdy_cnt, 1);
    access(1, 0, 8'h00, lat);
    oey = 1'b1; #1;
    chk("rdwr_y_3C", bif.y, 8'h3C);
    oey = 1'b0;

    // Busy ignore
    cyc_in(1, 0, 0, 8'h40);
    access(0, 1, 8'h77, lat);
    cyc_in(1, 0, 0, 8'h30);
    rdy_cnt = 0;
    cyc_in(0, 0, 1, 8'h11);
    cyc_in(1, 1, 1, 8'h40);
    wait_rdy(lat);
    idle(5);
    chk("busy_single_rdy", rdy_cnt, 1);
    cyc_in(1, 0, 0, 8'h30);
    access(1, 0, 8'h00, lat);
    oey = 1'b1; #1;
    chk("busy_addr_kept", bif.y, 8'h11);
    oey = 1'b0;
    cyc_in(1, 0, 0, 8'h40);
    access(1, 0, 8'h00, lat);
    oey = 1'b1; #1;
    chk("busy_no_2nd_wr", bif.y, 8'h77);
    oey = 1'b0;

    // Reset mid-operation aborts write
    cyc_in(1, 0, 0, 8'h50);
    access(0, 1, 8'h5A, lat);
    rdy_cnt = 0;
    cyc_in(0, 0, 1, 8'hFF);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    idle(8);
    chk("abort_no_rdy", rdy_cnt, 0);
    cyc_in(1, 0, 0, 8'h50);
    access(1, 0, 8'h00, lat);
    oey = 1'b1; #1;
    chk("abort_keeps_5A", bif.y, 8'h5A);
    oey = 1'b0;

    // Address wrap / auto-increment
    cyc_in(1, 0, 0, 8'h00);
    access(0, 1, 8'hC3, lat);
    cyc_in(1, 0, 0, 8'hFF);
    access(0, 1, 8'hE1, lat);
    cyc_in(1, 0, 0, 8'hFF);
    access(1, 0, 8'h00, lat);
    oey = 1'b1; #1;
    chk("rd_FF", bif.y, 8'hE1);
    access(1, 0, 8'h00, lat);
    #1;
`ifdef BUS_MEM_AUTOINC_EN
    chk("autoinc_wrap", bif.y, 8'hC3);
`else
    chk("no_autoinc", bif.y, 8'hE1);
`endif
    oey = 1'b0;
    idle(2);

    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
